res4b_serial: RTL and testbench



---
 rtl/res4b_serial.sv | 156 +++++++++++++++
 tb/tb_res4b_serial.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/res4b_serial.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus a borrow flop, LSB first.
// Define RES4B_ADD_EN to add the op port (op=1 subtract, op=0 add with carry out).
module res4b_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [WIDTH-1:0] xi,
    input  logic [WIDTH-1:0] yi,
`ifdef RES4B_ADD_EN
    input  logic             op,
`endif
    output logic [WIDTH-1:0] zi,
    output logic             co,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] r_r;
    logic             br_r;
    logic [CW-1:0]    cnt_r;
    logic             sub_r;
    logic [WIDTH-1:0] zi_r;
    logic             co_r;
    logic             busy_r;
    logic             done_r;
    logic             last_s;
    logic             diff_s;
    logic             br_s;
    logic             sub_s;

    function automatic logic borrow_f(input logic a, input logic b, input logic bin);
        return (~a & b) | (~(a ^ b) & bin);
    endfunction

    function automatic logic carry_f(input logic a, input logic b, input logic cin);
        return (a & b) | ((a ^ b) & cin);
    endfunction

`ifdef RES4B_ADD_EN
    assign sub_s = sub_r;
`else
    assign sub_s = 1'b1;
`endif

    assign last_s = (cnt_r == CW'(WIDTH - 1));

    // Serial cell: difference/sum bit and next borrow/carry from the operand LSBs.
    always_comb begin
        diff_s = a_r[0] ^ b_r[0] ^ br_r;
        if (sub_s) begin
            br_s = borrow_f(a_r[0], b_r[0], br_r);
        end else begin
            br_s = carry_f(a_r[0], b_r[0], br_r);
        end
    end

    // Next-state logic; init only matters in IDLE, DONE always returns to IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (init) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, serial shifting and result/flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            r_r    <= {WIDTH{1'b0}};
            br_r   <= 1'b0;
            cnt_r  <= {CW{1'b0}};
            sub_r  <= 1'b1;
            zi_r   <= {WIDTH{1'b0}};
            co_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            // busy/done are registered copies of the upcoming state.
            busy_r <= (state_s == SHIFT);
            done_r <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (init) begin
                        a_r   <= xi;
                        b_r   <= yi;
                        r_r   <= {WIDTH{1'b0}};
                        br_r  <= 1'b0;
                        cnt_r <= {CW{1'b0}};
`ifdef RES4B_ADD_EN
                        sub_r <= op;
`else
                        sub_r <= 1'b1;
`endif
                    end
                end
                SHIFT: begin
                    a_r   <= a_r >> 1;
                    b_r   <= b_r >> 1;
                    r_r   <= {diff_s, r_r[WIDTH-1:1]};
                    br_r  <= br_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (last_s) begin
                        zi_r <= {diff_s, r_r[WIDTH-1:1]};
                        co_r <= br_s;
                    end
                end
                default: ;
            endcase
        end
    end

    assign zi   = zi_r;
    assign co   = co_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_res4b_serial.sv
// Scoreboard bench for res4b_serial: stimulus pushes expected {co,zi}, a monitor pops on done.
module tb_res4b_serial;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         init;
    logic [W-1:0] xi;
    logic [W-1:0] yi;
    logic [W-1:0] zi;
    logic         co;
    logic         busy;
    logic         done;
`ifdef RES4B_ADD_EN
    logic         op;
`endif

    int checks   = 0;
    int failures = 0;
    int n_done   = 0;
    int n_push   = 0;
    int cyc      = 0;
    int last_done = -1;
    bit gap_chk  = 1'b0;
    logic [W:0]   exp_q[$];
    logic [W-1:0] held_zi;
    logic         held_co;

    always #5 clk = ~clk;

    res4b_serial #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .init (init),
        .xi   (xi),
        .yi   (yi),
`ifdef RES4B_ADD_EN
        .op   (op),
`endif
        .zi   (zi),
        .co   (co),
        .busy (busy),
        .done (done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compare every completion against the scoreboard; zi/co must hold while busy.
    always @(negedge clk) begin
        logic [W:0] e;
        if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("zi", int'(zi), int'(e[W-1:0]));
                chk("co", int'(co), int'(e[W]));
            end
            if (gap_chk && last_done >= 0) chk("done_gap", cyc - last_done, W + 2);
            last_done = cyc;
        end else if (busy) begin
            chk("zi_hold", int'(zi), int'(held_zi));
            chk("co_hold", int'(co), int'(held_co));
        end
        held_zi = zi;
        held_co = co;
    end

    task automatic issue(input int x, input int y, input int ez, input int eco, input bit push);
        @(negedge clk);
        xi   = W'(x);
        yi   = W'(y);
        init = 1'b1;
        if (push) begin
            exp_q.push_back({eco[0], ez[W-1:0]});
            n_push++;
        end
        @(negedge clk);
        init = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    int vec [4][4] = '{'{3, 9, 10, 1}, '{0, 0, 0, 0}, '{15, 15, 0, 0}, '{0, 1, 15, 1}};

    initial begin
        rst  = 1'b0;
        init = 1'b0;
        xi   = '0;
        yi   = '0;
`ifdef RES4B_ADD_EN
        op   = 1'b1;
`endif
        repeat (2) @(negedge clk);
        chk("rst_zi", int'(zi), 0);
        chk("rst_co", int'(co), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b1;

        // 9-3: busy for W cycles after acceptance, done on the following cycle.
        issue(9, 3, 6, 0, 1'b1);
        for (int k = 0; k <= W; k++) begin
            if (k > 0) @(negedge clk);
            chk("busy_timing", int'(busy), (k < W) ? 1 : 0);
            chk("done_timing", int'(done), (k == W) ? 1 : 0);
        end
        drain();

        for (int i = 0; i < 4; i++) begin
            issue(vec[i][0], vec[i][1], vec[i][2], vec[i][3], 1'b1);
            drain();
        end

        // Second init two cycles in is ignored.
        issue(9, 3, 6, 0, 1'b1);
        @(negedge clk);
        xi   = 4'd5;
        yi   = 4'd7;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        drain();
        repeat (10) @(negedge clk);

        // Reset two cycles into an operation.
        issue(3, 9, 10, 1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_zi", int'(zi), 0);
        chk("midrst_co", int'(co), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        issue(3, 9, 10, 1, 1'b1);
        drain();

        // Exhaustive sweep with init held high; operand inputs scrambled after capture.
        gap_chk   = 1'b1;
        last_done = -1;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                @(negedge clk);
                xi   = W'(x);
                yi   = W'(y);
                init = 1'b1;
                exp_q.push_back({(x < y) ? 1'b1 : 1'b0, W'((x - y) & 15)});
                n_push++;
                @(negedge clk);
                xi = W'($urandom);
                yi = W'($urandom);
                repeat (W) @(negedge clk);
            end
        end
        init = 1'b0;
        drain();
        gap_chk = 1'b0;

`ifdef RES4B_ADD_EN
        op = 1'b0;
        issue(9, 8, 1, 1, 1'b1);
        op = 1'b1;
        drain();
        issue(9, 8, 1, 0, 1'b1);
        drain();
`endif

        repeat (4) @(negedge clk);
        chk("done_count", n_done, n_push);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
